// File: rtl/gbd_cam_quantize.sv
// gbd_cam_quantize: quantizes an 8-bit luminance raster to 2-bit Game Boy
// shades through the 4x4x3 camera compare matrix, packs 4 pixels per byte
// and emits buffer byte writes plus one buffer flip per 8-row strip.
// Optional per-code pixel counters are built when GBD_QUANT_STATS_EN is defined.
module gbd_cam_quantize #(
    parameter int unsigned IMG_W      = 128,
    parameter int unsigned IMG_H      = 112,
    parameter int unsigned STRIP_ROWS = 8
) (
    input  logic        sys_clock,
    input  logic        sys_reset,
    input  logic        thr_wr_en,
    input  logic [5:0]  thr_wr_addr,
    input  logic [7:0]  thr_wr_data,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        buf_wr_req,
    output logic [9:0]  buf_wr_offset,
    output logic [7:0]  buf_wr_data,
    output logic        flip_buffer,
    output logic        frame_done,
    output logic        busy
`ifdef GBD_QUANT_STATS_EN
    ,
    output logic [14:0] stat_cnt0,
    output logic [14:0] stat_cnt1,
    output logic [14:0] stat_cnt2,
    output logic [14:0] stat_cnt3
`endif
);

    localparam int unsigned YW = $clog2(IMG_H + 1);
    localparam logic [YW-1:0] Y_END = YW'(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, WFLIP} state_t;

    state_t         state;
    logic [6:0]     x;
    logic [YW-1:0]  y;
    logic           bufsel;
    // Only the three previous codes are kept; the fourth joins them at the write.
    logic [5:0]     pack;
    logic [7:0]     mat [48];
    logic [5:0]     base;
    logic [7:0]     thr_l;
    logic [7:0]     thr_m;
    logic [7:0]     thr_h;
    logic [1:0]     code;
    logic           accept;
    logic           last_col;
    logic           strip_end;

    assign pix_ready = (state == RUN);
    assign busy      = (state != IDLE);
    assign accept    = pix_valid && pix_ready && !frame_start;
    assign last_col  = (x == 7'(IMG_W - 1));
    assign strip_end = last_col && ((32'(y) % STRIP_ROWS) == (STRIP_ROWS - 1));

    // Compare matrix storage; writable in any state, upper indices ignored.
    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            for (int unsigned i = 0; i < 48; i++) begin
                mat[i] <= '0;
            end
        end else if (thr_wr_en && (thr_wr_addr < 6'd48)) begin
            mat[thr_wr_addr] <= thr_wr_data;
        end
    end

    // Threshold selection by raster position and first-match quantization.
    always_comb begin
        base  = ({4'd0, y[1:0]} * 6'd12) + ({4'd0, x[1:0]} * 6'd3);
        thr_l = mat[base];
        thr_m = mat[base + 6'd1];
        thr_h = mat[base + 6'd2];
        if (pix_data < thr_l) begin
            code = 2'd3;
        end else if (pix_data < thr_m) begin
            code = 2'd2;
        end else if (pix_data < thr_h) begin
            code = 2'd1;
        end else begin
            code = 2'd0;
        end
    end

    // Frame/strip sequencing, pixel packing and buffer write/flip pulses.
    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            bufsel        <= 1'b0;
            pack          <= '0;
            buf_wr_req    <= 1'b0;
            buf_wr_offset <= '0;
            buf_wr_data   <= '0;
            flip_buffer   <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            buf_wr_req  <= 1'b0;
            flip_buffer <= 1'b0;
            frame_done  <= 1'b0;
            if (frame_start) begin
                state  <= RUN;
                x      <= '0;
                y      <= '0;
                bufsel <= 1'b0;
                pack   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        if (accept) begin
                            pack <= {pack[3:0], code};
                            if (x[1:0] == 2'd3) begin
                                buf_wr_req    <= 1'b1;
                                buf_wr_data   <= {pack, code};
                                buf_wr_offset <= {1'b0, bufsel, y[2:0], x[6:2]};
                            end
                            if (last_col) begin
                                x <= '0;
                                y <= y + 1'b1;
                                if (strip_end) begin
                                    state <= WFLIP;
                                end
                            end else begin
                                x <= x + 1'b1;
                            end
                        end
                    end
                    WFLIP: begin
                        flip_buffer <= 1'b1;
                        bufsel      <= ~bufsel;
                        if (y == Y_END) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef GBD_QUANT_STATS_EN
    logic [14:0] stat_q [4];

    // Saturating per-code counts of accepted pixels, cleared per frame.
    always_ff @(posedge sys_clock) begin
        if (sys_reset || frame_start) begin
            for (int unsigned i = 0; i < 4; i++) begin
                stat_q[i] <= '0;
            end
        end else if (accept && (stat_q[code] != '1)) begin
            stat_q[code] <= stat_q[code] + 1'b1;
        end
    end

    assign stat_cnt0 = stat_q[0];
    assign stat_cnt1 = stat_q[1];
    assign stat_cnt2 = stat_q[2];
    assign stat_cnt3 = stat_q[3];
`endif

endmodule

// File: tb/tb_gbd_cam_quantize.sv
// Self-checking bench for gbd_cam_quantize: vector table of threshold cases,
// hand sequences for the multi-cycle corners, and randomized frames checked
// against a position-based behavioural model with cycle-stamped expectations.
`timescale 1ns/1ps
module tb_gbd_cam_quantize;

    localparam int W = 128;
    localparam int H = 112;

    logic        sys_clock = 1'b0;
    logic        sys_reset = 1'b1;
    logic        thr_wr_en = 1'b0;
    logic [5:0]  thr_wr_addr = '0;
    logic [7:0]  thr_wr_data = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_ready;
    logic        buf_wr_req;
    logic [9:0]  buf_wr_offset;
    logic [7:0]  buf_wr_data;
    logic        flip_buffer;
    logic        frame_done;
    logic        busy;
`ifdef GBD_QUANT_STATS_EN
    logic [14:0] stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;
`endif

    always #5 sys_clock = ~sys_clock;

    gbd_cam_quantize #(.IMG_W(W), .IMG_H(H), .STRIP_ROWS(8)) dut (
        .sys_clock     (sys_clock),
        .sys_reset     (sys_reset),
        .thr_wr_en     (thr_wr_en),
        .thr_wr_addr   (thr_wr_addr),
        .thr_wr_data   (thr_wr_data),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .buf_wr_req    (buf_wr_req),
        .buf_wr_offset (buf_wr_offset),
        .buf_wr_data   (buf_wr_data),
        .flip_buffer   (flip_buffer),
        .frame_done    (frame_done),
        .busy          (busy)
`ifdef GBD_QUANT_STATS_EN
        ,
        .stat_cnt0     (stat_cnt0),
        .stat_cnt1     (stat_cnt1),
        .stat_cnt2     (stat_cnt2),
        .stat_cnt3     (stat_cnt3)
`endif
    );

    typedef struct { int c; int off; int data; } wr_t;
    typedef struct { int c; bit done; } fl_t;
    typedef struct { logic [7:0] l; logic [7:0] m; logic [7:0] h; logic [7:0] p; int code; } vec_t;

    wr_t wq[$];
    fl_t fq[$];
    vec_t tbl[12];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int mm[48];
    int codes[4];
    int scnt[4];
    bit armed = 0;
    bit gap = 0;
    int n = 0;
    int acc_total = 0;
    int wr_cnt = 0, flip_cnt = 0, done_cnt = 0;
    int last_off = -1, last_data = -1, last_wr_cyc = -1, ready_low = 0;
    int wr_mem[512];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int quant(input int p, input int x, input int y);
        int b;
        b = (y % 4) * 12 + (x % 4) * 3;
        if (p < mm[b]) return 3;
        if (p < mm[b + 1]) return 2;
        if (p < mm[b + 2]) return 1;
        return 0;
    endfunction

    // One clock: check outputs at the falling edge, then drive inputs and advance the model.
    task automatic step(input bit v, input logic [7:0] d, input bit fs,
                        input bit we, input logic [5:0] wa, input logic [7:0] wd);
        wr_t w;
        fl_t f;
        bit acc;
        int x, y, q;
        @(negedge sys_clock);
        cyc++;
        chk("pix_ready", int'(pix_ready), int'(armed && !gap));
        chk("busy", int'(busy), int'(armed || gap));
        if (!pix_ready) ready_low++;
        if (buf_wr_req) begin
            wr_cnt++;
            last_off = int'(buf_wr_offset);
            last_data = int'(buf_wr_data);
            last_wr_cyc = cyc;
            wr_mem[int'(buf_wr_offset[8:0])] = int'(buf_wr_data);
            chk("wr_cycle", cyc, (wq.size() > 0) ? wq[0].c : -1);
            if (wq.size() > 0 && wq[0].c == cyc) begin
                w = wq.pop_front();
                chk("wr_offset", int'(buf_wr_offset), w.off);
                chk("wr_data", int'(buf_wr_data), w.data);
            end
        end else if (wq.size() > 0 && wq[0].c <= cyc) begin
            void'(wq.pop_front());
            chk("wr_req", int'(buf_wr_req), 1);
        end
        if (frame_done) done_cnt++;
        if (flip_buffer) begin
            flip_cnt++;
            chk("flip_cycle", cyc, (fq.size() > 0) ? fq[0].c : -1);
            if (fq.size() > 0 && fq[0].c == cyc) begin
                f = fq.pop_front();
                chk("frame_done", int'(frame_done), int'(f.done));
            end
        end else begin
            if (frame_done) chk("done_with_flip", int'(flip_buffer), 1);
            if (fq.size() > 0 && fq[0].c <= cyc) begin
                void'(fq.pop_front());
                chk("flip_req", int'(flip_buffer), 1);
            end
        end

        pix_valid = v;
        pix_data = d;
        frame_start = fs;
        thr_wr_en = we;
        thr_wr_addr = wa;
        thr_wr_data = wd;

        acc = v && armed && !gap && !fs;
        if (fs) begin
            armed = 1;
            gap = 0;
            n = 0;
            foreach (scnt[i]) scnt[i] = 0;
            while (fq.size() > 0 && fq[$].c > cyc) void'(fq.pop_back());
        end else if (gap) begin
            gap = 0;
        end else if (acc) begin
            x = n % W;
            y = n / W;
            q = quant(int'(d), x, y);
            codes[x % 4] = q;
            if (scnt[q] < 32767) scnt[q]++;
            if (x % 4 == 3)
                wq.push_back('{cyc + 1, ((y / 8) % 2) * 256 + (y % 8) * 32 + x / 4,
                               codes[0] * 64 + codes[1] * 16 + codes[2] * 4 + codes[3]});
            acc_total++;
            n++;
            if (x == W - 1 && y % 8 == 7) begin
                gap = 1;
                fq.push_back('{cyc + 2, (y == H - 1)});
                if (y == H - 1) begin
                    armed = 0;
                    n = 0;
                end
            end
        end
        if (we && int'(wa) < 48) mm[int'(wa)] = int'(wd);
    endtask

    task automatic idle(input int k);
        repeat (k) step(0, 8'h00, 0, 0, 6'd0, 8'h00);
    endtask

    task automatic set_mat(input int a, input int v);
        step(0, 8'h00, 0, 1, 6'(a), 8'(v));
    endtask

    task automatic set_all(input int l, input int m, input int h);
        for (int p = 0; p < 16; p++) begin
            set_mat(p * 3, l);
            set_mat(p * 3 + 1, m);
            set_mat(p * 3 + 2, h);
        end
        set_mat(48 + $urandom_range(15), 8'hFF);
    endtask

    task automatic start_frame();
        step(0, 8'h00, 1, 0, 6'd0, 8'h00);
    endtask

    task automatic run(input int count, input bit rv, input bit rd, input logic [7:0] cd);
        int start;
        int budget;
        start = acc_total;
        budget = count * 4 + 100;
        while (acc_total - start < count && budget > 0) begin
            step(rv ? ($urandom_range(3) != 0) : 1'b1,
                 rd ? 8'($urandom_range(255)) : cd, 0, 0, 6'd0, 8'h00);
            budget--;
        end
        chk("run_accepts", acc_total - start, count);
    endtask

    task automatic do_reset();
        @(negedge sys_clock);
        cyc++;
        sys_reset = 1;
        pix_valid = 0;
        frame_start = 0;
        thr_wr_en = 0;
        @(negedge sys_clock);
        cyc++;
        @(negedge sys_clock);
        cyc++;
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_wr_req", int'(buf_wr_req), 0);
        chk("rst_wr_offset", int'(buf_wr_offset), 0);
        chk("rst_wr_data", int'(buf_wr_data), 0);
        chk("rst_flip", int'(flip_buffer), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef GBD_QUANT_STATS_EN
        chk("rst_stat3", int'(stat_cnt3), 0);
`endif
        sys_reset = 0;
        armed = 0;
        gap = 0;
        n = 0;
        wq.delete();
        fq.delete();
        foreach (mm[i]) mm[i] = 0;
        foreach (scnt[i]) scnt[i] = 0;
    endtask

    initial begin
        int wc, fc, dc, k4;
        tbl[0]  = '{8'h40, 8'h80, 8'hC0, 8'h00, 3};
        tbl[1]  = '{8'h40, 8'h80, 8'hC0, 8'h40, 2};
        tbl[2]  = '{8'h40, 8'h80, 8'hC0, 8'h7F, 2};
        tbl[3]  = '{8'h40, 8'h80, 8'hC0, 8'h80, 1};
        tbl[4]  = '{8'h40, 8'h80, 8'hC0, 8'hC0, 0};
        tbl[5]  = '{8'h40, 8'h80, 8'hC0, 8'hBF, 1};
        tbl[6]  = '{8'h80, 8'h40, 8'hC0, 8'h50, 3};
        tbl[7]  = '{8'h80, 8'h40, 8'hC0, 8'h90, 1};
        tbl[8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 0};
        tbl[9]  = '{8'h00, 8'h00, 8'hFF, 8'hFE, 1};
        tbl[10] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 0};
        tbl[11] = '{8'h20, 8'hFF, 8'h10, 8'h30, 2};

        // Reset, then pixels without frame_start are ignored.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 8'(i * 13), 0, 0, 6'd0, 8'h00);
        chk("idle_no_writes", wr_cnt, 0);

        // 0x00/0x50/0x90/0xFF over 0x40/0x80/0xC0 packs to 0xE4 one cycle after the 4th accept.
        set_all(8'h40, 8'h80, 8'hC0);
        start_frame();
        step(1, 8'h00, 0, 0, 6'd0, 8'h00);
        step(1, 8'h50, 0, 0, 6'd0, 8'h00);
        step(1, 8'h90, 0, 0, 6'd0, 8'h00);
        step(1, 8'hFF, 0, 0, 6'd0, 8'h00);
        k4 = cyc;
        idle(2);
        chk("e4_data", last_data, 8'hE4);
        chk("e4_offset", last_off, 0);
        chk("e4_latency", last_wr_cyc, k4 + 1);

        // Threshold vector table: four identical pixels give the code replicated.
        for (int t = 0; t < 12; t++) begin
            set_all(tbl[t].l, tbl[t].m, tbl[t].h);
            start_frame();
            wc = wr_cnt;
            repeat (4) step(1, tbl[t].p, 0, 0, 6'd0, 8'h00);
            idle(2);
            chk("tbl_data", last_data, tbl[t].code * 8'h55);
            chk("tbl_writes", wr_cnt - wc, 1);
        end

        // Position-specific thresholds at (x%4=1, y%4=2).
        set_all(8'h40, 8'h80, 8'hC0);
        set_mat(27, 8'h10);
        set_mat(28, 8'h20);
        set_mat(29, 8'h30);
        wr_mem[0] = -1;
        wr_mem[64] = -1;
        start_frame();
        for (int i = 0; i < 2 * W + 4; i++)
            step(1, (i == 1 || i == 2 * W + 1) ? 8'h10 : 8'hFF, 0, 0, 6'd0, 8'h00);
        idle(2);
        chk("pos_y0_code3", wr_mem[0], 8'h30);
        chk("pos_y2_code2", wr_mem[64], 8'h20);
        wr_mem[64] = -1;
        start_frame();
        for (int i = 0; i < 2 * W + 4; i++)
            step(1, (i == 2 * W + 1) ? 8'h0F : 8'hFF, 0, 0, 6'd0, 8'h00);
        idle(2);
        chk("pos_y2_code3", wr_mem[64], 8'h30);

        // Two full strips with valid held high.
        set_all(8'h40, 8'h80, 8'hC0);
        start_frame();
        wc = wr_cnt;
        fc = flip_cnt;
        ready_low = 0;
        run(1024, 0, 1, 8'h00);
        run(1024, 0, 1, 8'h00);
        chk("strip_ready_low", ready_low, 1);
        idle(3);
        chk("strip_writes", wr_cnt - wc, 512);
        chk("strip_flips", flip_cnt - fc, 2);
        chk("strip_last_off", last_off, 10'h1FF);

        // Restart mid-pack, frame_start priority, matrix write timing.
        set_all(8'h40, 8'h80, 8'hC0);
        start_frame();
        repeat (6) step(1, 8'h50, 0, 0, 6'd0, 8'h00);
        wc = wr_cnt;
        step(1, 8'h50, 1, 0, 6'd0, 8'h00);
        step(1, 8'h50, 0, 0, 6'd0, 8'h00);
        step(1, 8'h50, 0, 1, 6'd3, 8'h60);
        step(1, 8'h50, 0, 0, 6'd0, 8'h00);
        step(1, 8'h50, 0, 0, 6'd0, 8'h00);
        idle(2);
        chk("restart_writes", wr_cnt - wc, 1);
        chk("restart_offset", last_off, 0);
        chk("restart_old_thr", last_data, 8'hAA);
        start_frame();
        repeat (4) step(1, 8'h50, 0, 0, 6'd0, 8'h00);
        idle(2);
        chk("restart_new_thr", last_data, 8'hBA);

        // Full frame, random thresholds, random pixels and gaps in pix_valid.
        for (int a = 0; a < 48; a++) set_mat(a, $urandom_range(255));
        start_frame();
        wc = wr_cnt;
        fc = flip_cnt;
        dc = done_cnt;
        run(W * H, 1, 1, 8'h00);
        idle(4);
        chk("frame_writes", wr_cnt - wc, 3584);
        chk("frame_flips", flip_cnt - fc, 14);
        chk("frame_dones", done_cnt - dc, 1);
        chk("frame_idle_ready", int'(pix_ready), 0);
        chk("frame_idle_busy", int'(busy), 0);

        // Constant dark frame.
        set_all(8'h40, 8'h80, 8'hC0);
        start_frame();
        run(W * H, 0, 0, 8'h00);
        idle(4);
        wc = wr_cnt;
        repeat (3) step(1, 8'h00, 0, 0, 6'd0, 8'h00);
        chk("post_done_ignored", wr_cnt - wc, 0);
`ifdef GBD_QUANT_STATS_EN
        chk("stat0", int'(stat_cnt0), 0);
        chk("stat1", int'(stat_cnt1), 0);
        chk("stat2", int'(stat_cnt2), 0);
        chk("stat3", int'(stat_cnt3), 14336);
        chk("stat3_model", int'(stat_cnt3), scnt[3]);
`endif

        // Reset mid-frame: no flip or done afterwards, matrix cleared.
        set_all(8'h40, 8'h80, 8'hC0);
        start_frame();
        run(300, 0, 1, 8'h00);
        do_reset();
        fc = flip_cnt;
        idle(5);
        chk("midrst_no_flip", flip_cnt - fc, 0);
        last_data = -1;
        start_frame();
        repeat (4) step(1, 8'($urandom_range(255)), 0, 0, 6'd0, 8'h00);
        idle(2);
        chk("midrst_matrix_clear", last_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
